// File: rtl/lpf_mux_sequencer.sv
// Four-pole ladder low-pass for N_CH channels. One shared signed multiplier is
// stepped through RES, SAT and L1..L4 for each channel once per sample_clk frame.
module lpf_mux_sequencer #(
    parameter int W    = 16,
    parameter int N_CH = 4,
    parameter int CLIP = 32000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_clk,
    input  logic [N_CH*W-1:0] g,
    input  logic [N_CH*W-1:0] resonance,
    input  logic [N_CH*W-1:0] sample_in,
    output logic [N_CH*W-1:0] sample_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int W2 = 2 * W;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
    localparam logic signed [W2-1:0] CLIP_HI = W2'(CLIP);
    localparam logic signed [W2-1:0] CLIP_LO = -CLIP_HI;

    typedef enum logic [2:0] {
        S_IDLE, S_RES, S_SAT, S_L1, S_L2, S_L3, S_L4, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          ch, ch_nxt;
    int                     chi;
    logic                   sample_clk_q, trig;
    logic [N_CH*W-1:0]      g_sh, res_sh, in_sh, stage, stage_nxt;
    logic signed [W2-1:0]   rezz [N_CH];
    logic signed [W2-1:0]   pole [N_CH][4];
    logic signed [W2-1:0]   sat;
    logic signed [W-1:0]    in_w, g_w, res_w, y_w;
    logic signed [W2-1:0]   x, y, r, gg;
    logic signed [W2-1:0]   cur_rezz, clamped, sat_diff, sat_x31, sat_nxt;
    logic signed [W2-1:0]   p_in, p_cur, pole_nxt;
    logic signed [W2-1:0]   mul_a, mul_b, mul_res;
    logic signed [2*W2-1:0] prod;

    assign trig = sample_clk & ~sample_clk_q;
    assign chi  = int'(ch);

    // Current channel operands, taken from the frame shadow and the previous output.
    assign in_w  = in_sh[chi*W +: W];
    assign g_w   = g_sh[chi*W +: W];
    assign res_w = res_sh[chi*W +: W];
    assign y_w   = sample_out[chi*W +: W];
    assign x     = {{W{in_w[W-1]}}, in_w};
    assign y     = {{W{y_w[W-1]}}, y_w};
    assign r     = res_w[W-1] ? {W2{1'b0}} : {{(W-1){1'b0}}, res_w, 1'b0};
    assign gg    = g_w[W-1] ? {W2{1'b0}} : {{W{1'b0}}, g_w};

    // Pole stage operand selection: previous pole output and this pole's state.
    always_comb begin
        p_in  = sat;
        p_cur = pole[ch][0];
        case (state)
            S_L2:    begin p_in = pole[ch][0]; p_cur = pole[ch][1]; end
            S_L3:    begin p_in = pole[ch][1]; p_cur = pole[ch][2]; end
            S_L4:    begin p_in = pole[ch][2]; p_cur = pole[ch][3]; end
            default: begin p_in = sat;         p_cur = pole[ch][0]; end
        endcase
    end

    // Shared multiplier operand mux: feedback term in RES, pole update otherwise.
    always_comb begin
        mul_a = p_in - p_cur;
        mul_b = gg;
        if (state == S_RES) begin
            mul_a = y - x;
            mul_b = r;
        end else begin
            mul_a = p_in - p_cur;
            mul_b = gg;
        end
    end

    assign prod     = mul_a * mul_b;
    assign mul_res  = W2'(prod >>> W);
    assign pole_nxt = p_cur + mul_res;

    // Soft saturation: pull rezz 31/32 of the way towards its clamped value.
    assign cur_rezz = rezz[ch];
    always_comb begin
        clamped = cur_rezz;
        if (cur_rezz > CLIP_HI) begin
            clamped = CLIP_HI;
        end else if (cur_rezz < CLIP_LO) begin
            clamped = CLIP_LO;
        end else begin
            clamped = cur_rezz;
        end
    end
    assign sat_diff = clamped - cur_rezz;
    assign sat_x31  = (sat_diff <<< 3'd5) - sat_diff;
    assign sat_nxt  = cur_rezz + (sat_x31 >>> 3'd5);

    // Staging lanes, with the L4 result forwarded so the last channel lands with the rest.
    always_comb begin
        stage_nxt = stage;
        if (state == S_L4) begin
            stage_nxt[chi*W +: W] = pole_nxt[W-1:0];
        end else begin
            stage_nxt = stage;
        end
    end

    // Sequencer next-state and channel stepping.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            S_IDLE: begin
                if (trig) begin
                    state_nxt = S_RES;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RES: state_nxt = S_SAT;
            S_SAT: state_nxt = S_L1;
            S_L1:  state_nxt = S_L2;
            S_L2:  state_nxt = S_L3;
            S_L3:  state_nxt = S_L4;
            S_L4: begin
                if (ch == LAST_CH) begin
                    state_nxt = S_DONE;
                    ch_nxt    = {CW{1'b0}};
                end else begin
                    state_nxt = S_RES;
                    ch_nxt    = ch + CW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                ch_nxt    = {CW{1'b0}};
            end
        endcase
    end

    // Control registers, trigger history, input shadow and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ch           <= {CW{1'b0}};
            sample_clk_q <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            g_sh         <= {(N_CH*W){1'b0}};
            res_sh       <= {(N_CH*W){1'b0}};
            in_sh        <= {(N_CH*W){1'b0}};
        end else begin
            state        <= state_nxt;
            ch           <= ch_nxt;
            sample_clk_q <= sample_clk;
            busy         <= (state_nxt != S_IDLE);
            out_valid    <= (state_nxt == S_DONE);
            if (trig && (state == S_IDLE)) begin
                g_sh   <= g;
                res_sh <= resonance;
                in_sh  <= sample_in;
            end
            if (trig && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Filter state, staging and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                rezz[k] <= {W2{1'b0}};
                for (int i = 0; i < 4; i++) begin
                    pole[k][i] <= {W2{1'b0}};
                end
            end
            sat        <= {W2{1'b0}};
            stage      <= {(N_CH*W){1'b0}};
            sample_out <= {(N_CH*W){1'b0}};
        end else begin
            stage <= stage_nxt;
            case (state)
                S_RES: rezz[ch]    <= x - mul_res;
                S_SAT: sat         <= sat_nxt;
                S_L1:  pole[ch][0] <= pole_nxt;
                S_L2:  pole[ch][1] <= pole_nxt;
                S_L3:  pole[ch][2] <= pole_nxt;
                S_L4: begin
                    pole[ch][3] <= pole_nxt;
                    if (ch == LAST_CH) begin
                        sample_out <= stage_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lpf_mux_sequencer.sv
// Directed bench for lpf_mux_sequencer: a frame-level arithmetic model is
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_lpf_mux_sequencer;
    localparam int W     = 16;
    localparam int N_CH  = 4;
    localparam int FRAME = 6 * N_CH + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_clk = 1'b0;
    logic [N_CH*W-1:0] g = '0;
    logic [N_CH*W-1:0] resonance = '0;
    logic [N_CH*W-1:0] sample_in = '0;
    logic [N_CH*W-1:0] sample_out;
    logic              out_valid, busy, overrun;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;

    // Frame-level model: filter state, committed/pending outputs, remaining busy cycles.
    int         m_a [N_CH][4];
    logic [W-1:0] m_out [N_CH];
    logic [W-1:0] m_pend [N_CH];
    int         m_rem;
    bit         m_q, m_ov;

    always #5 clk = ~clk;

    lpf_mux_sequencer #(.W(W), .N_CH(N_CH), .CLIP(32000)) dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .g(g), .resonance(resonance),
        .sample_in(sample_in), .sample_out(sample_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [N_CH*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            for (int i = 0; i < 4; i++) m_a[k][i] = 0;
            m_out[k]  = '0;
            m_pend[k] = '0;
        end
        m_rem = 0;
        m_q   = 1'b0;
        m_ov  = 1'b0;
    endtask

    // One whole frame of the recurrence in plain integer arithmetic.
    task automatic run_frame();
        for (int k = 0; k < N_CH; k++) begin
            int x, y, r, gg, rz, c, d, t, prev;
            longint p;
            x  = int'($signed(sample_in[k*W +: W]));
            y  = int'($signed(m_out[k]));
            r  = int'($signed(resonance[k*W +: W]));
            r  = (r < 0) ? 0 : r * 2;
            gg = int'($signed(g[k*W +: W]));
            gg = (gg < 0) ? 0 : gg;
            d  = y - x;
            p  = longint'(d) * longint'(r);
            rz = x - int'(p >>> 16);
            c  = (rz > 32000) ? 32000 : ((rz < -32000) ? -32000 : rz);
            d  = c - rz;
            t  = d * 31;
            prev = rz + (t >>> 5);
            for (int i = 0; i < 4; i++) begin
                d = prev - m_a[k][i];
                p = longint'(d) * longint'(gg);
                m_a[k][i] = m_a[k][i] + int'(p >>> 16);
                prev = m_a[k][i];
            end
            m_pend[k] = W'(m_a[k][3]);
        end
    endtask

    task automatic model_step();
        bit trig;
        if (rst) begin
            model_reset();
        end else begin
            trig = sample_clk && !m_q;
            m_q  = sample_clk;
            if (m_rem > 0) begin
                if (trig) m_ov = 1'b1;
                m_rem--;
            end else if (trig) begin
                m_rem = FRAME;
                run_frame();
            end
            if (m_rem == 1) begin
                for (int k = 0; k < N_CH; k++) m_out[k] = m_pend[k];
            end
        end
    endtask

    // Advance one clock: model first, then compare all outputs on the falling edge.
    task automatic tick();
        logic [N_CH*W-1:0] exp_out;
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N_CH; k++) exp_out[k*W +: W] = m_out[k];
        check("busy", busy, m_rem > 0);
        check("out_valid", out_valid, m_rem == 1);
        check("overrun", overrun, m_ov);
        check("sample_out", sample_out, exp_out);
        if (out_valid === 1'b1) valid_cnt++;
    endtask

    task automatic frame();
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        repeat (FRAME + 2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        valid_cnt = 0;
    endtask

    initial begin
        int busy_cnt, valid_at;
        logic signed [W-1:0] sq;

        // Reset values.
        tick();
        check("rst_sample_out", sample_out, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Single trigger: busy spans 25 cycles, out_valid in cycle 25 after the edge.
        sample_clk = 1'b1;
        tick();
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        valid_at = (out_valid === 1'b1) ? 1 : -1;
        sample_clk = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1 && valid_at < 0) valid_at = c;
        end
        check("busy_cycles", busy_cnt, 25);
        check("valid_latency", valid_at, 25);

        // DC step on ch0; first frame is 8000 halved four times with floor.
        sample_in[0 +: W] = 16'd8000;
        g[0 +: W]         = 16'd32767;
        frame();
        check("dc_first_frame", lane(sample_out, 0), 499);
        repeat (199) frame();
        // Each truncating pole settles 2 LSB short of its input.
        check("dc_settled", lane(sample_out, 0), 7992);

        // Reset in cycle 10 of a frame: outputs cleared, no pulse afterwards.
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        repeat (8) tick();
        valid_cnt = 0;
        rst = 1'b1;
        #1;
        check("midrst_sample_out", sample_out, 0);
        check("midrst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        check("midrst_no_valid", valid_cnt, 0);
        frame();
        check("post_rst_clean_frame", lane(sample_out, 0), 499);

        // Channel isolation.
        do_reset();
        g         = {N_CH{16'd16384}};
        sample_in = '0;
        sample_in[2*W +: W] = -16'sd12000;
        repeat (20) frame();
        check("iso_ch0", lane(sample_out, 0), 0);
        check("iso_ch1", lane(sample_out, 1), 0);
        check("iso_ch3", lane(sample_out, 3), 0);

        // Freeze with g=0 after convergence.
        do_reset();
        g         = '0;
        sample_in = '0;
        g[W +: W]         = 16'd32767;
        sample_in[W +: W] = 16'd5000;
        repeat (100) frame();
        check("freeze_settled", lane(sample_out, 1), 4992);
        g[W +: W]         = 16'd0;
        sample_in[W +: W] = -16'sd5000;
        repeat (5) frame();
        check("freeze_hold", lane(sample_out, 1), 4992);

        // Second trigger 10 clocks into a frame.
        do_reset();
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        repeat (9) tick();
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        repeat (40) tick();
        check("overrun_set", overrun, 1);
        check("overrun_one_valid", valid_cnt, 1);

        // sample_clk held high: a single frame.
        do_reset();
        sample_clk = 1'b1;
        repeat (60) tick();
        sample_clk = 1'b0;
        repeat (5) tick();
        check("level_one_valid", valid_cnt, 1);
        check("level_no_overrun", overrun, 0);

        // Full resonance with a +/-30000 square on every channel.
        do_reset();
        g         = {N_CH{16'd32767}};
        resonance = {N_CH{16'd32767}};
        for (int f = 0; f < 40; f++) begin
            sq = (((f / 4) % 2) == 0) ? 16'sd30000 : -16'sd30000;
            sample_in = {N_CH{sq}};
            frame();
            if (f == 0) check("clamp_first_frame", lane(sample_out, 0), 2053);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
